dual_demux_steer: RTL and testbench

DUAL_DEMUX_STEER -- requirements
Module: dual_demux_steer

---
 rtl/dual_demux_steer_pkg.sv | 24 ++
 rtl/dual_demux_steer_valid.sv | 18 +
 rtl/dual_demux_steer.sv | 129 ++++++++++++
 tb/tb_dual_demux_steer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_demux_steer_pkg.sv
// Shared definitions for the dual-rail one-into-two steering block:
// codeword constants, the handshake state enum and a route helper.
package dual_demux_steer_pkg;

  // Dual-rail codewords
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_DATA0   = 2'b01;
  localparam logic [1:0] DR_DATA1   = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  // Four-phase handshake position of the token in flight
  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    OUT_DATA  = 2'd1,
    WAIT_NULL = 2'd2,
    OUT_NULL  = 2'd3
  } steerState_t;

  // A valid select codeword routes to B when its high rail is set
  function automatic logic routeToB(input logic [1:0] selCode);
    return selCode == DR_DATA1;
  endfunction

endpackage

// File: rtl/dual_demux_steer_valid.sv
// Classifies one dual-rail codeword as NULL, single-rail DATA or illegal.
module dr_valid
  import dual_demux_steer_pkg::*;
(
  input  logic [1:0] code,
  output logic       isNull,
  output logic       isData,
  output logic       isIllegal
);

  // Pure decode; exactly one of the three flags is high
  always_comb begin
    isNull    = (code == DR_NULL);
    isData    = (code == DR_DATA0) || (code == DR_DATA1);
    isIllegal = (code == DR_ILLEGAL);
  end

endmodule

// File: rtl/dual_demux_steer.sv
// Split-side counterpart of the two-into-one arbiter: one four-phase
// return-to-NULL input flow is steered token-by-token to consumer A or B.
// All outputs are registered; the unselected output always stays NULL.
module dual_demux_steer
  import dual_demux_steer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             init,
  input  logic [1:0]       dualIn,
  output logic             dualInCOMP,
  input  logic [1:0]       sel,
  output logic [1:0]       dualA,
  input  logic             dualACOMP,
  output logic [1:0]       dualB,
  input  logic             dualBCOMP,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB,
  output logic             err
);

  logic inNull, inData, inIllegal;
  logic selNull, selData, selIllegal;

  dr_valid uInValid (
    .code      (dualIn),
    .isNull    (inNull),
    .isData    (inData),
    .isIllegal (inIllegal)
  );

  dr_valid uSelValid (
    .code      (sel),
    .isNull    (selNull),
    .isData    (selData),
    .isIllegal (selIllegal)
  );

  steerState_t      state, stateNxt;
  logic [1:0]       dataLat, dataLatNxt;
  logic             chanB, chanBNxt;
  logic [1:0]       dualANxt, dualBNxt;
  logic             compNxt;
  logic [CNT_W-1:0] cntANxt, cntBNxt;
  logic             errNxt;
  logic             selComp;

  // Only the completion of the channel carrying the current token matters
  assign selComp = chanB ? dualBCOMP : dualACOMP;

  // Next-state and next-output decode; everything holds unless a step fires
  always_comb begin
    stateNxt   = state;
    dataLatNxt = dataLat;
    chanBNxt   = chanB;
    dualANxt   = dualA;
    dualBNxt   = dualB;
    compNxt    = dualInCOMP;
    cntANxt    = cntA;
    cntBNxt    = cntB;
    errNxt     = err;
    unique case (state)
      WAIT_DATA: begin
        if (inIllegal || selIllegal) begin
          errNxt = 1'b1;
        end else if (inData && selData) begin
          dataLatNxt = dualIn;
          chanBNxt   = routeToB(sel);
          dualANxt   = routeToB(sel) ? DR_NULL : dualIn;
          dualBNxt   = routeToB(sel) ? dualIn : DR_NULL;
          stateNxt   = OUT_DATA;
        end
      end
      OUT_DATA: begin
        dualANxt = chanB ? DR_NULL : dataLat;
        dualBNxt = chanB ? dataLat : DR_NULL;
        if (selComp) begin
          compNxt  = 1'b1;
          stateNxt = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        dualANxt = chanB ? DR_NULL : dataLat;
        dualBNxt = chanB ? dataLat : DR_NULL;
        if (inNull && selNull) begin
          dualANxt = DR_NULL;
          dualBNxt = DR_NULL;
          stateNxt = OUT_NULL;
        end
      end
      OUT_NULL: begin
        if (!selComp) begin
          compNxt  = 1'b0;
          stateNxt = WAIT_DATA;
          if (chanB) cntBNxt = cntB + CNT_W'(1);
          else       cntANxt = cntA + CNT_W'(1);
        end
      end
      default: stateNxt = WAIT_DATA;
    endcase
  end

  // State and output registers; init abandons any token in flight
  always_ff @(posedge clk) begin
    if (init) begin
      state      <= WAIT_DATA;
      dataLat    <= DR_NULL;
      chanB      <= 1'b0;
      dualA      <= DR_NULL;
      dualB      <= DR_NULL;
      dualInCOMP <= 1'b0;
      cntA       <= '0;
      cntB       <= '0;
      err        <= 1'b0;
    end else begin
      state      <= stateNxt;
      dataLat    <= dataLatNxt;
      chanB      <= chanBNxt;
      dualA      <= dualANxt;
      dualB      <= dualBNxt;
      dualInCOMP <= compNxt;
      cntA       <= cntANxt;
      cntB       <= cntBNxt;
      err        <= errNxt;
    end
  end

endmodule

// File: tb/tb_dual_demux_steer.sv
// Bench for dual_demux_steer: a table of tokens, hand-written corner
// sequences and randomized tokens checked against a token-level model.
module tb_dual_demux_steer;

  logic       clk = 1'b0;
  logic       init;
  logic [1:0] dualIn, sel;
  logic       dualACOMP, dualBCOMP;

  logic       dualInCOMP;
  logic [1:0] dualA, dualB;
  logic [7:0] cntA, cntB;
  logic       err;

  logic       dualInCOMP2;
  logic [1:0] dualA2, dualB2;
  logic [1:0] cntA2, cntB2;
  logic       err2;

  always #5 clk = ~clk;

  dual_demux_steer #(.CNT_W(8)) dut (
    .clk(clk), .init(init), .dualIn(dualIn), .dualInCOMP(dualInCOMP),
    .sel(sel), .dualA(dualA), .dualACOMP(dualACOMP), .dualB(dualB),
    .dualBCOMP(dualBCOMP), .cntA(cntA), .cntB(cntB), .err(err)
  );

  dual_demux_steer #(.CNT_W(2)) dutNarrow (
    .clk(clk), .init(init), .dualIn(dualIn), .dualInCOMP(dualInCOMP2),
    .sel(sel), .dualA(dualA2), .dualACOMP(dualACOMP), .dualB(dualB2),
    .dualBCOMP(dualBCOMP), .cntA(cntA2), .cntB(cntB2), .err(err2)
  );

  // Token-level reference: delivered tokens per channel and sticky error
  int   nTests = 0;
  int   nFail  = 0;
  int   cntAM, cntBM;
  logic errM;

  typedef struct {
    logic [1:0] selV;
    logic [1:0] inV;
    logic [1:0] expA;
    logic [1:0] expB;
    int         dDly;
    int         nDly;
    bit         perturb;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkCounts(input string nm);
    chk({nm, ".cntA"}, cntA, cntAM % 256);
    chk({nm, ".cntB"}, cntB, cntBM % 256);
    chk({nm, ".cntA2"}, cntA2, cntAM % 4);
    chk({nm, ".cntB2"}, cntB2, cntBM % 4);
    chk({nm, ".err"}, err, errM);
    chk({nm, ".err2"}, err2, errM);
  endtask

  task automatic resetAll();
    init = 1'b1; dualIn = 2'b01; sel = 2'b01;
    dualACOMP = 1'b0; dualBCOMP = 1'b0;
    tick();
    tick();
    cntAM = 0; cntBM = 0; errM = 1'b0;
    chk("rst.dualA", dualA, 2'b00);
    chk("rst.dualB", dualB, 2'b00);
    chk("rst.comp", dualInCOMP, 1'b0);
    chkCounts("rst");
    init = 1'b0; dualIn = 2'b00; sel = 2'b00;
  endtask

  // Full four-phase exchange of one token with the selected consumer
  task automatic doToken(input logic [1:0] selV, input logic [1:0] inV,
                         input logic [1:0] expA, input logic [1:0] expB,
                         input int dDly, input int nDly, input bit perturb);
    bit isB;
    isB = (selV == 2'b10);
    dualIn = inV; sel = selV;
    tick();
    chk("data.dualA", dualA, expA);
    chk("data.dualB", dualB, expB);
    chk("data.comp", dualInCOMP, 1'b0);
    for (int i = 0; i < dDly; i++) begin
      if (perturb) begin
        dualIn = 2'($urandom);
        sel    = 2'($urandom);
      end
      tick();
      chk("hold.dualA", dualA, expA);
      chk("hold.dualB", dualB, expB);
      chk("hold.comp", dualInCOMP, 1'b0);
    end
    if (isB) dualBCOMP = 1'b1;
    else     dualACOMP = 1'b1;
    tick();
    chk("ack.comp", dualInCOMP, 1'b1);
    chk("ack.dualA", dualA, expA);
    chk("ack.dualB", dualB, expB);
    dualIn = 2'b00; sel = 2'b00;
    tick();
    chk("null.dualA", dualA, 2'b00);
    chk("null.dualB", dualB, 2'b00);
    chk("null.cntA", cntA, cntAM % 256);
    chk("null.cntB", cntB, cntBM % 256);
    for (int i = 0; i < nDly; i++) begin
      tick();
      chk("nullHold.comp", dualInCOMP, 1'b1);
    end
    dualACOMP = 1'b0; dualBCOMP = 1'b0;
    tick();
    if (isB) cntBM++;
    else     cntAM++;
    chk("done.comp", dualInCOMP, 1'b0);
    chkCounts("done");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 1'b0};
    tbl[1] = '{2'b01, 2'b10, 2'b10, 2'b00, 0, 0, 1'b0};
    tbl[2] = '{2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 1'b0};
    tbl[3] = '{2'b10, 2'b10, 2'b00, 2'b10, 0, 0, 1'b0};
    tbl[4] = '{2'b10, 2'b01, 2'b00, 2'b01, 20, 0, 1'b1};
    tbl[5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2, 3, 1'b1};
    tbl[6] = '{2'b10, 2'b10, 2'b00, 2'b10, 1, 1, 1'b0};
    tbl[7] = '{2'b01, 2'b10, 2'b10, 2'b00, 3, 0, 1'b0};

    resetAll();
    for (int i = 0; i < 8; i++)
      doToken(tbl[i].selV, tbl[i].inV, tbl[i].expA, tbl[i].expB,
              tbl[i].dDly, tbl[i].nDly, tbl[i].perturb);

    // Illegal codewords while idle: sticky err, no output activity
    dualIn = 2'b11; sel = 2'b01;
    tick();
    errM = 1'b1;
    chk("ill.err", err, 1'b1);
    chk("ill.dualA", dualA, 2'b00);
    chk("ill.dualB", dualB, 2'b00);
    chk("ill.comp", dualInCOMP, 1'b0);
    dualIn = 2'b01; sel = 2'b11;
    tick();
    chk("illSel.err", err, 1'b1);
    chk("illSel.dualA", dualA, 2'b00);
    chk("illSel.dualB", dualB, 2'b00);
    dualIn = 2'b00; sel = 2'b00;
    tick();
    doToken(2'b01, 2'b10, 2'b10, 2'b00, 0, 0, 1'b0);

    // Randomized tokens with half-valid idle gaps
    for (int t = 0; t < 40; t++) begin
      logic [1:0] d, s, eA, eB;
      int gap;
      d   = 2'($urandom_range(1, 2));
      s   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      eA  = (s == 2'b01) ? d : 2'b00;
      eB  = (s == 2'b10) ? d : 2'b00;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if (g % 2 == 0) begin dualIn = d; sel = 2'b00; end
        else            begin dualIn = 2'b00; sel = s; end
        tick();
        chk("gap.dualA", dualA, 2'b00);
        chk("gap.dualB", dualB, 2'b00);
      end
      doToken(s, d, eA, eB, $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end

    // Narrow counter wraps 1,2,3,0,1
    resetAll();
    begin
      logic [1:0] wrapExp[5];
      wrapExp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 5; k++) begin
        doToken(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 1'b0);
        chk("wrap.cntA2", cntA2, wrapExp[k]);
      end
    end

    // init while DATA is out: token abandoned, back to WAIT_DATA
    resetAll();
    dualIn = 2'b01; sel = 2'b01;
    tick();
    chk("abort.dataA", dualA, 2'b01);
    init = 1'b1;
    tick();
    chk("abort.dualA", dualA, 2'b00);
    chk("abort.comp", dualInCOMP, 1'b0);
    chk("abort.cntA", cntA, 0);
    init = 1'b0;
    tick();
    chk("relatch.dualA", dualA, 2'b01);
    dualACOMP = 1'b1;
    tick();
    chk("relatch.comp", dualInCOMP, 1'b1);
    dualIn = 2'b00; sel = 2'b00;
    tick();
    dualACOMP = 1'b0;
    tick();
    cntAM = 1;
    chk("relatch.cntA", cntA, 1);
    chkCounts("relatch");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
